// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: the pipeline writeback has fixed priority, and
// long-latency unit results are queued in order. A pending scoreboard drives the decode stall.
module regfile_wb_arbiter #(
  parameter int WORD     = 32,
  parameter int REG_NUM  = 32,
  parameter int ADDR_W   = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_reg,
  input  logic [WORD-1:0]   i_wb_data,
  input  logic              i_lu_valid,
  output logic              o_lu_ready,
  input  logic [ADDR_W-1:0] i_lu_reg,
  input  logic [WORD-1:0]   i_lu_data,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_reg,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  output logic              o_stall,
  output logic              o_rf_write_en,
  output logic [ADDR_W-1:0] o_rf_write_reg,
  output logic [WORD-1:0]   o_rf_write_data
);
  localparam int LQ_AW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;

  logic [ADDR_W-1:0]  r_q_reg  [LQ_DEPTH];
  logic [WORD-1:0]    r_q_data [LQ_DEPTH];
  logic [LQ_AW:0]     r_wptr;
  logic [LQ_AW:0]     r_rptr;
  logic [REG_NUM-1:0] r_pending;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_reg;
  logic [WORD-1:0]    r_wr_data;
  logic               r_wr_src_lu;

  logic               w_empty;
  logic               w_full;
  logic               w_lu_fire;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic               w_sel_valid;
  logic               w_sel_lu;
  logic [ADDR_W-1:0]  w_sel_reg;
  logic [WORD-1:0]    w_sel_data;
  logic               w_issue_set;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[LQ_AW] != r_rptr[LQ_AW]) &&
                      (r_wptr[LQ_AW-1:0] == r_rptr[LQ_AW-1:0]);
  assign o_lu_ready = !i_rst && !w_full;
  assign w_lu_fire  = i_lu_valid && o_lu_ready;
  assign w_pop      = !i_wb_valid && !w_empty;
  assign w_bypass   = !i_wb_valid && w_empty && w_lu_fire;
  assign w_push     = w_lu_fire && !w_bypass;
  assign w_issue_set = i_issue_valid && (i_issue_reg != {ADDR_W{1'b0}}) && !r_pending[i_issue_reg];

  assign o_stall = r_pending[i_rs1] | r_pending[i_rs2] | (i_issue_valid & r_pending[i_issue_reg]);

  assign o_rf_write_en   = r_wr_en;
  assign o_rf_write_reg  = r_wr_reg;
  assign o_rf_write_data = r_wr_data;

  // Write-port selection: writeback, then FIFO head, then LU bypass.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_lu    = 1'b0;
    w_sel_reg   = r_wr_reg;
    w_sel_data  = r_wr_data;
    if (i_wb_valid) begin
      w_sel_valid = 1'b1;
      w_sel_reg   = i_wb_reg;
      w_sel_data  = i_wb_data;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_lu    = 1'b1;
      w_sel_reg   = r_q_reg[r_rptr[LQ_AW-1:0]];
      w_sel_data  = r_q_data[r_rptr[LQ_AW-1:0]];
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_lu    = 1'b1;
      w_sel_reg   = i_lu_reg;
      w_sel_data  = i_lu_data;
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  // FIFO pointers and registered write port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
      r_wr_src_lu <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + {{LQ_AW{1'b0}}, 1'b1};
      if (w_pop)  r_rptr <= r_rptr + {{LQ_AW{1'b0}}, 1'b1};
      // Destination 0 is consumed without a write.
      r_wr_en     <= w_sel_valid && (w_sel_reg != {ADDR_W{1'b0}});
      r_wr_src_lu <= w_sel_lu;
      r_wr_reg    <= w_sel_reg;
      r_wr_data   <= w_sel_data;
    end
  end

  // FIFO storage needs no reset; pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_reg[r_wptr[LQ_AW-1:0]]  <= i_lu_reg;
      r_q_data[r_wptr[LQ_AW-1:0]] <= i_lu_data;
    end
  end

  // Pending scoreboard; a set on the same edge overrides the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      if (r_wr_en && r_wr_src_lu) r_pending[r_wr_reg] <= 1'b0;
      if (w_issue_set)            r_pending[i_issue_reg] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected register-file writes are queued
// in write order and compared at negedge as the DUT produces them.
module tb_regfile_wb_arbiter;
  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid, issue_valid;
  logic [4:0]  wb_reg, lu_reg, issue_reg, rs1, rs2;
  logic [31:0] wb_data, lu_data;
  logic        lu_ready, stall, rf_write_en;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  int  n_checks = 0;
  int  n_pass   = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_valid(wb_valid), .i_wb_reg(wb_reg), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .o_lu_ready(lu_ready), .i_lu_reg(lu_reg), .i_lu_data(lu_data),
    .i_issue_valid(issue_valid), .i_issue_reg(issue_reg),
    .i_rs1(rs1), .i_rs2(rs2), .o_stall(stall),
    .o_rf_write_en(rf_write_en), .o_rf_write_reg(rf_write_reg), .o_rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    lu_valid = 1'b0;
    issue_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1; wb_reg = r; wb_data = d;
  endtask

  task automatic lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1; lu_reg = r; lu_data = d;
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{r: r, d: d});
  endtask

  // Scoreboard: every write the DUT makes must be the next one expected.
  always @(negedge clk) begin
    if (!rst && rf_write_en) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_reg", 64'(rf_write_reg), 64'(e.r));
        chk("write_data", 64'(rf_write_data), 64'(e.d));
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    wb_reg = 5'd0; wb_data = 32'd0; lu_reg = 5'd0; lu_data = 32'd0;
    issue_reg = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    step(); step();
    chk("reset_en", 64'(rf_write_en), 64'd0);
    chk("reset_reg", 64'(rf_write_reg), 64'd0);
    chk("reset_data", 64'(rf_write_data), 64'd0);
    chk("reset_lu_ready", 64'(lu_ready), 64'd0);
    rst = 1'b0;
    step();
    chk("post_reset_lu_ready", 64'(lu_ready), 64'd1);

    // T1: plain writeback
    wb(5'd3, 32'hA5); expect_wr(5'd3, 32'hA5);
    step();
    idle(); rs1 = 5'd3; rs2 = 5'd5; #1;
    chk("t1_en", 64'(rf_write_en), 64'd1);
    chk("t1_no_pending", 64'(stall), 64'd0);
    step();
    chk("t1_idle_en", 64'(rf_write_en), 64'd0);
    chk("t1_hold_reg", 64'(rf_write_reg), 64'd3);
    chk("t1_hold_data", 64'(rf_write_data), 64'hA5);

    // T2: issue, stall, LU bypass write, stall release
    rs1 = 5'd0; rs2 = 5'd0;
    issue_valid = 1'b1; issue_reg = 5'd5; #1;
    chk("t2_issue_no_stall", 64'(stall), 64'd0);
    step();
    issue_valid = 1'b0; rs1 = 5'd5; #1;
    chk("t2_rs1_stall", 64'(stall), 64'd1);
    rs1 = 5'd0; issue_valid = 1'b1; issue_reg = 5'd5; #1;
    chk("t2_reissue_stall", 64'(stall), 64'd1);
    issue_valid = 1'b0; rs1 = 5'd5;
    lu(5'd5, 32'h77); expect_wr(5'd5, 32'h77); #1;
    chk("t2_lu_ready", 64'(lu_ready), 64'd1);
    step();
    idle(); #1;
    chk("t2_write_en", 64'(rf_write_en), 64'd1);
    chk("t2_stall_during_write", 64'(stall), 64'd1);
    step();
    chk("t2_stall_cleared", 64'(stall), 64'd0);
    rs1 = 5'd0;

    // T3: WB held 4 cycles while LU queues two results
    for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'h100 + 32'(i));
    expect_wr(5'd6, 32'h1); expect_wr(5'd7, 32'h2);
    wb(5'd10, 32'h100); lu(5'd6, 32'h1);
    step();
    wb(5'd11, 32'h101); lu(5'd7, 32'h2);
    step();
    lu_valid = 1'b0; wb(5'd12, 32'h102); #1;
    chk("t3_full_ready_c2", 64'(lu_ready), 64'd0);
    step();
    wb(5'd13, 32'h103); #1;
    chk("t3_full_ready_c3", 64'(lu_ready), 64'd0);
    step();
    wb_valid = 1'b0; #1;
    chk("t3_pop_no_passthru", 64'(lu_ready), 64'd0);
    step();
    chk("t3_ready_back", 64'(lu_ready), 64'd1);
    step(); step();

    // T4: full FIFO with LU valid and WB idle
    expect_wr(5'd14, 32'hE); expect_wr(5'd15, 32'hF);
    expect_wr(5'd20, 32'hA); expect_wr(5'd21, 32'hB); expect_wr(5'd22, 32'hC);
    wb(5'd14, 32'hE); lu(5'd20, 32'hA);
    step();
    wb(5'd15, 32'hF); lu(5'd21, 32'hB);
    step();
    wb_valid = 1'b0; lu(5'd22, 32'hC); #1;
    chk("t4_full_ready", 64'(lu_ready), 64'd0);
    step();
    chk("t4_ready_after_pop", 64'(lu_ready), 64'd1);
    step();
    idle();
    step(); step(); step();
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // T5: destination 0 from both sources
    wb(5'd0, 32'h99); lu(5'd0, 32'h5);
    step();
    idle(); #1;
    chk("t5_wb_r0_no_write", 64'(rf_write_en), 64'd0);
    step();
    chk("t5_lu_r0_no_write", 64'(rf_write_en), 64'd0);
    chk("t5_lu_ready", 64'(lu_ready), 64'd1);
    lu(5'd8, 32'h55); expect_wr(5'd8, 32'h55);
    step();
    idle(); #1;
    chk("t5_bypass_after_drain", 64'(rf_write_en), 64'd1);
    step();

    // T6: reset with two queued entries and pending[9]
    issue_valid = 1'b1; issue_reg = 5'd9;
    step();
    issue_valid = 1'b0; rs1 = 5'd9; #1;
    chk("t6_pending9", 64'(stall), 64'd1);
    wb(5'd0, 32'h0); lu(5'd16, 32'h16);
    step();
    wb(5'd0, 32'h0); lu(5'd17, 32'h17);
    step();
    idle(); rst = 1'b1; #1;
    chk("t6_ready_in_reset", 64'(lu_ready), 64'd0);
    step();
    chk("t6_reset_en", 64'(rf_write_en), 64'd0);
    rst = 1'b0;
    step(); step(); step();
    chk("t6_stall_cleared", 64'(stall), 64'd0);
    chk("t6_lu_ready", 64'(lu_ready), 64'd1);
    chk("t6_no_write", 64'(rf_write_en), 64'd0);
    rs1 = 5'd0;
    step(); step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
